// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_EXT
    } owner_t;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_WIDTH        = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_stall;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_rvalid;

    logic                  ext_req;
    logic                  ext_we;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic                  ext_gnt;
    logic [DATA_WIDTH-1:0] ext_rdata;
    logic                  ext_rvalid;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != MAX)) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, ext is forced through
// after STARVE_LIMIT consecutive denied cycles. Reads return one cycle later.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    owner_t                owner;
    logic [CNT_WIDTH-1:0]  starve_cnt;
    logic                  ext_gnt_w;

    logic                  cpu_rvalid_reg;
    logic                  ext_rvalid_reg;
    logic [DATA_WIDTH-1:0] cpu_rdata_reg;
    logic [DATA_WIDTH-1:0] ext_rdata_reg;

    always_comb begin
        owner = OWN_NONE;
        if (bus.cpu_req && bus.ext_req) begin
            owner = (starve_cnt == LIMIT) ? OWN_EXT : OWN_CPU;
        end else if (bus.cpu_req) begin
            owner = OWN_CPU;
        end else if (bus.ext_req) begin
            owner = OWN_EXT;
        end
    end

    assign ext_gnt_w     = (owner == OWN_EXT);
    assign bus.ext_gnt   = ext_gnt_w;
    assign bus.cpu_stall = bus.cpu_req && (owner != OWN_CPU);

    // The loser never reaches the memory port, so its write cannot leak through.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        case (owner)
            OWN_CPU: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_we    = bus.cpu_we;
                bus.mem_re    = !bus.cpu_we;
            end
            OWN_EXT: begin
                bus.mem_addr  = bus.ext_addr;
                bus.mem_wdata = bus.ext_wdata;
                bus.mem_we    = bus.ext_we;
                bus.mem_re    = !bus.ext_we;
            end
            default: ;
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (ext_gnt_w || !bus.ext_req),
        .inc   (bus.ext_req && !ext_gnt_w),
        .count (starve_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid_reg <= 1'b0;
            ext_rvalid_reg <= 1'b0;
            cpu_rdata_reg  <= '0;
            ext_rdata_reg  <= '0;
        end else begin
            cpu_rvalid_reg <= (owner == OWN_CPU) && !bus.cpu_we;
            ext_rvalid_reg <= (owner == OWN_EXT) && !bus.ext_we;
            if ((owner == OWN_CPU) && !bus.cpu_we) begin
                cpu_rdata_reg <= bus.mem_rdata;
            end
            if ((owner == OWN_EXT) && !bus.ext_we) begin
                ext_rdata_reg <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_rvalid = cpu_rvalid_reg;
    assign bus.ext_rvalid = ext_rvalid_reg;
    assign bus.cpu_rdata  = cpu_rdata_reg;
    assign bus.ext_rdata  = ext_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory environment: combinational read, synchronous write, plus a preload port
    logic [DW-1:0] mem [256] = '{default: '0};
    logic          pre_we = 1'b0;
    logic [7:0]    pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_we && reset) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    // Reference model state
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    int            denied = 0;
    logic          exp_cpu_rvalid = 1'b0, exp_ext_rvalid = 1'b0;
    logic [DW-1:0] exp_cpu_rdata = '0, exp_ext_rdata = '0;
    bit            cpu_won, ext_won;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst_in,
                        input bit c_req, input bit c_we, input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                        input bit e_req, input bit e_we, input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd);
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        bit x_we, any;
        @(negedge clk);
        reset         = rst_in;
        bus.cpu_req   = c_req;  bus.cpu_we   = c_we;
        bus.cpu_addr  = c_addr; bus.cpu_wdata = c_wd;
        bus.ext_req   = e_req;  bus.ext_we   = e_we;
        bus.ext_addr  = e_addr; bus.ext_wdata = e_wd;
        #1;
        if (!rst_in) begin
            denied = 0;
            exp_cpu_rvalid = 0; exp_ext_rvalid = 0;
            exp_cpu_rdata = '0; exp_ext_rdata = '0;
        end
        // Ext wins when alone, or when it has waited LIMIT cycles in a row
        ext_won = e_req && (!c_req || denied >= LIMIT);
        cpu_won = c_req && !ext_won;
        any     = cpu_won || ext_won;
        x_addr  = ext_won ? e_addr : (cpu_won ? c_addr : '0);
        x_wd    = ext_won ? e_wd   : (cpu_won ? c_wd   : '0);
        x_we    = ext_won ? e_we   : c_we;
        chk("cpu_stall", 64'(bus.cpu_stall), 64'(c_req && !cpu_won));
        chk("ext_gnt",   64'(bus.ext_gnt),   64'(ext_won));
        chk("mem_we",    64'(bus.mem_we),    64'(any && x_we));
        chk("mem_re",    64'(bus.mem_re),    64'(any && !x_we));
        chk("mem_addr",  64'(bus.mem_addr),  64'(x_addr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(x_wd));
        if (rst_in) begin
            denied = (e_req && !ext_won) ? ((denied + 1 > LIMIT) ? LIMIT : denied + 1) : 0;
            exp_cpu_rvalid = cpu_won && !c_we;
            exp_ext_rvalid = ext_won && !e_we;
            if (exp_cpu_rvalid) exp_cpu_rdata = ref_mem[c_addr[7:0]];
            if (exp_ext_rvalid) exp_ext_rdata = ref_mem[e_addr[7:0]];
            if (any && x_we) ref_mem[x_addr[7:0]] = x_wd;
        end
        @(posedge clk);
        #1;
        chk("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(exp_cpu_rvalid));
        chk("ext_rvalid", 64'(bus.ext_rvalid), 64'(exp_ext_rvalid));
        chk("cpu_rdata",  64'(bus.cpu_rdata),  64'(exp_cpu_rdata));
        chk("ext_rdata",  64'(bus.ext_rdata),  64'(exp_ext_rdata));
        $display("step rst=%0b cpu(req=%0b we=%0b a=%0h) ext(req=%0b we=%0b a=%0h) cpu_won=%0b ext_won=%0b",
                 rst_in, c_req, c_we, c_addr, e_req, e_we, e_addr, cpu_won, ext_won);
    endtask

    task automatic idle(input bit rst_in);
        step(rst_in, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        idle(1);
        pre_we = 1'b0;
    endtask

    initial begin
        bit c_p, e_p, c_w, e_w;
        logic [AW-1:0] c_a, e_a;
        logic [DW-1:0] c_d, e_d;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;

        // Reset state
        idle(0);
        idle(0);
        idle(1);

        // CPU alone reads 0x10
        preload(8'h10, 32'hDEADBEEF);
        step(1, 1, 0, 32'h10, '0, 0, 0, '0, '0);
        chk("cpu_read_data", 64'(bus.cpu_rdata), 64'h0000_0000_DEAD_BEEF);

        // Ext alone writes then reads 0x20
        step(1, 0, 0, '0, '0, 1, 1, 32'h20, 32'h1234);
        step(1, 0, 0, '0, '0, 1, 0, 32'h20, '0);
        chk("ext_read_data", 64'(bus.ext_rdata), 64'h1234);

        // Continuous contention: ext wins every 5th cycle
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 32'(i), '0, 1, 0, 32'h20, '0);
            chk("fair_slot", 64'(ext_won), 64'((i % 5) == 4));
        end

        // Ext requests 2 cycles, drops 1, re-requests: granted after 4 more denials
        step(1, 1, 0, 32'h1, '0, 1, 0, 32'h20, '0);
        step(1, 1, 0, 32'h2, '0, 1, 0, 32'h20, '0);
        step(1, 1, 0, 32'h3, '0, 0, 0, 32'h20, '0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 32'(i), '0, 1, 0, 32'h20, '0);
            chk("drop_slot", 64'(ext_won), 64'(i == 4));
        end

        // Same-address write collision: only the CPU write lands
        step(1, 1, 1, 32'h30, 32'hA, 1, 1, 32'h30, 32'hB);
        step(1, 1, 0, 32'h30, '0, 0, 0, '0, '0);
        chk("collision_cpu_wins", 64'(bus.cpu_rdata), 64'hA);
        step(1, 0, 0, '0, '0, 1, 1, 32'h30, 32'hB);
        step(1, 0, 0, '0, '0, 1, 0, 32'h30, '0);
        chk("collision_ext_later", 64'(bus.ext_rdata), 64'hB);

        // Reset in the cycle after a granted CPU read
        step(1, 1, 0, 32'h10, '0, 1, 0, 32'h20, '0);
        idle(0);
        chk("reset_cpu_rdata", 64'(bus.cpu_rdata), 64'h0);
        step(1, 1, 0, 32'h10, '0, 0, 0, '0, '0);
        chk("post_reset_read", 64'(bus.cpu_rdata), 64'h0000_0000_DEAD_BEEF);

        // Random traffic; a denied requester holds its request until granted
        c_p = 0; e_p = 0; c_w = 0; e_w = 0;
        c_a = '0; e_a = '0; c_d = '0; e_d = '0;
        for (int i = 0; i < 300; i++) begin
            if (!c_p) begin
                c_p = ($urandom_range(0, 3) != 0);
                c_w = $urandom_range(0, 1) == 1;
                c_a = 32'($urandom_range(0, 15));
                c_d = $urandom;
            end
            if (!e_p) begin
                e_p = ($urandom_range(0, 2) != 0);
                e_w = $urandom_range(0, 1) == 1;
                e_a = 32'($urandom_range(0, 15));
                e_d = $urandom;
            end
            step(1, c_p, c_w, c_a, c_d, e_p, e_w, e_a, e_d);
            if (cpu_won) c_p = 0;
            if (ext_won) e_p = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
